// File: rtl/mprj_check_monitor.sv
// Watches a firmware-driven checkpoint code on user IO and grades the test as
// PASS, FAIL (wrong check, wrong sequence) or TIMEOUT after a debounce filter.
module mprj_check_monitor #(
    parameter int              CW             = 4,
    parameter logic [CW-1:0]   START_CODE     = 4'h5,
    parameter logic [CW-1:0]   FINAL_CODE     = 4'hD,
    parameter int              STABLE_CYCLES  = 2,
    parameter int              TIMEOUT_CYCLES = 25000,
    localparam int             TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic          clock,
    input  logic          resetb,
    input  logic          enable,
    input  logic [CW-1:0] check_in,
    output logic          busy,
    output logic          done,
    output logic          passed,
    output logic          failed,
    output logic [1:0]    fail_reason,
    output logic [CW-1:0] last_code,
    output logic [CW-1:0] pass_count,
    output logic [TW-1:0] elapsed
);

    localparam int            SW           = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX     = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_ONE     = SW'(1);
    localparam logic [TW-1:0] TIME_ONE     = TW'(1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CODE_ONE     = CW'(1);
    localparam logic [CW-1:0] CODE_TWO     = CW'(2);

    localparam logic [1:0] RSN_NONE    = 2'b00;
    localparam logic [1:0] RSN_CHECK   = 2'b01;
    localparam logic [1:0] RSN_SEQ     = 2'b10;
    localparam logic [1:0] RSN_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_RUN        = 3'd2,
        ST_PASS       = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cand_q;
    logic [SW-1:0] stab_q;
    logic [CW-1:0] exp_q;
    logic [CW-1:0] last_q;
    logic [CW-1:0] pcnt_q;
    logic [TW-1:0] elapsed_q;
    logic [1:0]    reason_q;
    logic          busy_q;
    logic          passed_q;
    logic          failed_q;
    logic          done_q;

    logic [SW-1:0] stab_d;
    logic [TW-1:0] elapsed_d;
    logic [CW-1:0] exp_minus1_s;
    logic          changed_s;
    logic          accept_s;
    logic          timeout_s;
    logic          hit_s;
    logic          go_run_s;
    logic          go_pass_s;
    logic          go_fail_s;
    logic [1:0]    reason_s;

    // Debounce filter: acceptance only on the edge the count first reaches the target.
    always_comb begin
        changed_s = (check_in != cand_q);
        if (changed_s) begin
            stab_d = STAB_ONE;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + STAB_ONE;
        end else begin
            stab_d = stab_q;
        end
        accept_s     = (stab_d == STAB_MAX) && ((stab_q != STAB_MAX) || changed_s)
                       && (check_in != last_q);
        elapsed_d    = elapsed_q + TIME_ONE;
        timeout_s    = (elapsed_d == TIMEOUT_LAST);
        exp_minus1_s = exp_q - CODE_ONE;
    end

    // Transition decisions; a terminal acceptance outranks a same-edge timeout.
    always_comb begin
        hit_s     = 1'b0;
        go_run_s  = 1'b0;
        go_pass_s = 1'b0;
        go_fail_s = 1'b0;
        reason_s  = RSN_NONE;
        if (state_q == ST_WAIT_START) begin
            if (accept_s && (check_in == START_CODE)) begin
                go_run_s = 1'b1;
            end else if (timeout_s) begin
                go_fail_s = 1'b1;
                reason_s  = RSN_TIMEOUT;
            end else begin
                go_run_s = 1'b0;
            end
        end else if (state_q == ST_RUN) begin
            if (accept_s && (check_in == exp_q)) begin
                hit_s = 1'b1;
                if (exp_q == FINAL_CODE) begin
                    go_pass_s = 1'b1;
                end else if (timeout_s) begin
                    go_fail_s = 1'b1;
                    reason_s  = RSN_TIMEOUT;
                end else begin
                    go_pass_s = 1'b0;
                end
            end else if (accept_s && (check_in == exp_minus1_s)) begin
                go_fail_s = 1'b1;
                reason_s  = RSN_CHECK;
            end else if (accept_s) begin
                go_fail_s = 1'b1;
                reason_s  = RSN_SEQ;
            end else if (timeout_s) begin
                go_fail_s = 1'b1;
                reason_s  = RSN_TIMEOUT;
            end else begin
                go_fail_s = 1'b0;
            end
        end else begin
            hit_s = 1'b0;
        end
    end

    // Monitor FSM with registered status outputs.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb || !enable) begin
            state_q   <= ST_IDLE;
            cand_q    <= '0;
            stab_q    <= '0;
            exp_q     <= '0;
            last_q    <= '0;
            pcnt_q    <= '0;
            elapsed_q <= '0;
            reason_q  <= RSN_NONE;
            busy_q    <= 1'b0;
            passed_q  <= 1'b0;
            failed_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q   <= ST_WAIT_START;
                    cand_q    <= '0;
                    stab_q    <= '0;
                    exp_q     <= START_CODE + CODE_TWO;
                    last_q    <= '0;
                    pcnt_q    <= '0;
                    elapsed_q <= '0;
                    reason_q  <= RSN_NONE;
                    busy_q    <= 1'b1;
                end
                ST_WAIT_START, ST_RUN: begin
                    cand_q    <= check_in;
                    stab_q    <= stab_d;
                    elapsed_q <= elapsed_d;
                    if (accept_s) begin
                        last_q <= check_in;
                    end
                    if (hit_s) begin
                        pcnt_q <= pcnt_q + CODE_ONE;
                        exp_q  <= exp_q + CODE_TWO;
                    end
                    if (go_pass_s) begin
                        state_q  <= ST_PASS;
                        busy_q   <= 1'b0;
                        passed_q <= 1'b1;
                        done_q   <= 1'b1;
                    end else if (go_fail_s) begin
                        state_q  <= ST_FAIL;
                        reason_q <= reason_s;
                        busy_q   <= 1'b0;
                        failed_q <= 1'b1;
                        done_q   <= 1'b1;
                    end else if (go_run_s) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_PASS, ST_FAIL: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign passed      = passed_q;
    assign failed      = failed_q;
    assign fail_reason = reason_q;
    assign last_code   = last_q;
    assign pass_count  = pcnt_q;
    assign elapsed     = elapsed_q;

endmodule

// File: tb/tb_mprj_check_monitor.sv
// Scoreboard bench for mprj_check_monitor: scenarios push the expected verdict,
// a monitor pops and compares it when done rises.
module tb_mprj_check_monitor;

    logic       clock = 1'b0;
    logic       resetb;
    logic       enable;
    logic [3:0] check_in;
    logic       busy, done, passed, failed;
    logic [1:0] fail_reason;
    logic [3:0] last_code, pass_count;
    logic [9:0] elapsed;

    mprj_check_monitor #(.TIMEOUT_CYCLES(1000)) dut (
        .clock(clock), .resetb(resetb), .enable(enable), .check_in(check_in),
        .busy(busy), .done(done), .passed(passed), .failed(failed),
        .fail_reason(fail_reason), .last_code(last_code),
        .pass_count(pass_count), .elapsed(elapsed)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       pass;
        logic [1:0] reason;
        logic [3:0] last;
        logic [3:0] pcnt;
        int         elapsed;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input string name, input logic p, input logic [1:0] r,
                        input logic [3:0] l, input logic [3:0] c, input int e);
        exp_t x;
        x.name = name; x.pass = p; x.reason = r; x.last = l; x.pcnt = c; x.elapsed = e;
        sb_q.push_back(x);
    endtask

    // Monitor: compare the terminal verdict against the scoreboard on each rising done.
    logic done_prev = 1'b0;
    exp_t cur;
    always @(negedge clock) begin
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                cur = sb_q.pop_front();
                chk({cur.name, "_passed"},  32'(passed),      32'(cur.pass));
                chk({cur.name, "_failed"},  32'(failed),      32'(!cur.pass));
                chk({cur.name, "_busy"},    32'(busy),        32'd0);
                chk({cur.name, "_reason"},  32'(fail_reason), 32'(cur.reason));
                chk({cur.name, "_last"},    32'(last_code),   32'(cur.last));
                chk({cur.name, "_pcount"},  32'(pass_count),  32'(cur.pcnt));
                chk({cur.name, "_elapsed"}, 32'(elapsed),     32'(cur.elapsed));
            end
        end
        done_prev <= done;
    end

    task automatic hold(input logic [3:0] code, input int n);
        check_in = code;
        repeat (n) @(negedge clock);
    endtask

    // Disable, confirm the cleared state, enable; returns just before edge 1 of monitoring.
    task automatic start_test(input string name);
        @(negedge clock);
        enable   = 1'b0;
        check_in = 4'h0;
        repeat (2) @(negedge clock);
        chk({name, "_idle_outputs"},
            32'({busy, done, passed, failed, fail_reason, last_code, pass_count, elapsed}), 32'd0);
        enable = 1'b1;
        @(negedge clock);
        chk({name, "_busy_armed"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (!done && i < budget) begin
            @(negedge clock);
            i++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout_wait actual=0 required=1", name);
        end
        @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetb   = 1'b0;
        enable   = 1'b0;
        check_in = 4'h0;
        #12;
        chk("reset_outputs",
            32'({busy, done, passed, failed, fail_reason, last_code, pass_count, elapsed}), 32'd0);
        @(negedge clock);
        resetb = 1'b1;

        // Full pass: D first sampled at edge 41, accepted at 42.
        push("pass", 1'b1, 2'b00, 4'hD, 4'd4, 42);
        start_test("pass");
        hold(4'h5, 10); hold(4'h7, 10); hold(4'h9, 10); hold(4'hB, 10); hold(4'hD, 10);
        wait_done("pass", 100);

        // 8 is expected-minus-one after 7 was passed.
        push("check", 1'b0, 2'b01, 4'h8, 4'd1, 22);
        start_test("check");
        hold(4'h5, 10); hold(4'h7, 10); hold(4'h8, 10);
        wait_done("check", 100);

        push("sequence", 1'b0, 2'b10, 4'h9, 4'd0, 12);
        start_test("sequence");
        hold(4'h5, 10); hold(4'h9, 10);
        wait_done("sequence", 100);

        // One-cycle glitch to 6 never accepted; 7 accepted at 13, D at 43.
        push("glitch", 1'b1, 2'b00, 4'hD, 4'd4, 43);
        start_test("glitch");
        hold(4'h5, 10); hold(4'h6, 1); hold(4'h7, 10); hold(4'h9, 10);
        hold(4'hB, 10); hold(4'hD, 10);
        wait_done("glitch", 100);

        push("timeout", 1'b0, 2'b11, 4'h0, 4'd0, 999);
        start_test("timeout");
        hold(4'h0, 990);
        wait_done("timeout", 100);

        // D accepted on edge 999, the timeout edge: pass wins.
        push("race", 1'b1, 2'b00, 4'hD, 4'd4, 999);
        start_test("race");
        hold(4'h5, 10); hold(4'h7, 10); hold(4'h9, 10); hold(4'hB, 967); hold(4'hD, 2);
        wait_done("race", 100);

        // Asynchronous reset in RUN, away from any clock edge.
        start_test("areset");
        hold(4'h5, 10); hold(4'h7, 5);
        chk("areset_pre_busy", 32'(busy), 32'd1);
        chk("areset_pre_last", 32'(last_code), 32'h7);
        #2;
        resetb = 1'b0;
        enable = 1'b0;
        #1;
        chk("areset_outputs",
            32'({busy, done, passed, failed, fail_reason, last_code, pass_count, elapsed}), 32'd0);
        @(negedge clock);
        resetb = 1'b1;

        push("restart", 1'b1, 2'b00, 4'hD, 4'd4, 42);
        start_test("restart");
        hold(4'h5, 10); hold(4'h7, 10); hold(4'h9, 10); hold(4'hB, 10); hold(4'hD, 10);
        wait_done("restart", 100);

        start_test("final");
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mprj_check_monitor.md
MPRJ_CHECK_MONITOR -- requirements
Module: mprj_check_monitor

Interface
REQ-001 SHALL have parameter CW, default 4, the checkpoint code width in bits.
REQ-002 SHALL have parameter START_CODE, default 4'h5, the code that announces test start.
REQ-003 SHALL have parameter FINAL_CODE, default 4'hD, the last pass code; FINAL_CODE-START_CODE is even and at least 2.
REQ-004 SHALL have parameter STABLE_CYCLES, default 2 (at least 1), the consecutive identical samples needed to accept a code.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 25000, the cycle budget from start of monitoring; TW = $clog2(TIMEOUT_CYCLES+1).
REQ-006 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port resetb, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1, a level that arms monitoring; low clears status.
REQ-009 SHALL have port check_in, input, CW, the checkpoint field driven by firmware on user IO pins.
REQ-010 SHALL have outputs busy, done, passed and failed, each 1 bit: monitoring, terminal, terminal pass and terminal fail.
REQ-011 SHALL have port fail_reason, output, 2: 00 none, 01 CHECK, 10 SEQUENCE, 11 TIMEOUT.
REQ-012 SHALL have ports last_code and pass_count, output, CW: the last accepted code and the number of pass checkpoints.
REQ-013 SHALL have port elapsed, output, TW, cycles since entry to WAIT_START, frozen on entry to a terminal state.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT_START, RUN, PASS and FAIL.
REQ-015 SHALL make busy=1 only in WAIT_START or RUN, done=passed|failed, passed=1 only in PASS, and failed=1 only in FAIL.
REQ-016 SHALL filter check_in as follows: a changed value restarts a stability count at 1; a value is accepted on the edge its count reaches STABLE_CYCLES, provided it differs from last_code.
REQ-017 SHALL update state and outputs for an acceptance exactly STABLE_CYCLES-1 edges after the edge where the new value is first sampled.
REQ-018 SHALL move IDLE to WAIT_START on the first edge with enable=1, clearing elapsed, last_code, pass_count, fail_reason and the filter, and setting expected code E=START_CODE+2.
REQ-019 SHALL, in WAIT_START, move to RUN on acceptance of START_CODE and ignore all other accepted codes, while still updating last_code.
REQ-020 SHALL, in RUN, handle an accepted code c as follows: c==E increments pass_count and sets E+=2; c==E with E==FINAL_CODE goes to PASS; c==E-1 goes to FAIL with CHECK; any other c goes to FAIL with SEQUENCE.
REQ-021 SHALL increment elapsed each cycle in WAIT_START and RUN; when elapsed reaches TIMEOUT_CYCLES-1 with no terminal acceptance on that edge, it SHALL go to FAIL with TIMEOUT.
REQ-022 SHALL give an acceptance that causes PASS or FAIL priority over a timeout on the same edge.
REQ-023 SHALL hold PASS and FAIL, with all outputs frozen, while enable=1, ignoring check_in.
REQ-024 SHALL return from any state to IDLE on the edge after enable is sampled low, clearing all outputs to their reset values.
REQ-025 SHALL wrap E and pass_count modulo 2^CW without further checking.

Reset
REQ-026 SHALL, while resetb=0, asynchronously force state IDLE and all outputs to 0, including fail_reason=00, last_code=0 and elapsed=0.
REQ-027 SHALL, on resetb asserted mid-test, abandon the test; after release, monitoring restarts only via IDLE to WAIT_START.

Verification
REQ-028 SHALL be verified with defaults and TIMEOUT_CYCLES=1000 for the following scenario: enable, then codes 5,7,9,B,D each held 10 cycles -> PASS, passed=1, pass_count=4, last_code=D, fail_reason=00.
REQ-029 SHALL be verified for the following scenario: codes 5,7,8 -> FAIL, fail_reason=01, last_code=8, pass_count=1.
REQ-030 SHALL be verified for the following scenario: codes 5,9 -> FAIL, fail_reason=10; and a 1-cycle glitch to 6 between 5 and 7 is ignored, finishing in PASS.
REQ-031 SHALL be verified for the following scenario: enable with check_in held at 0 -> FAIL, fail_reason=11, elapsed=999; a later enable low -> IDLE with all outputs 0.
REQ-032 SHALL be verified for the following scenario: code D accepted on the same edge elapsed reaches 999 -> PASS, not TIMEOUT.
REQ-033 SHALL be verified for the following scenario: resetb pulsed low while in RUN -> outputs 0 immediately, without waiting for an edge, and the next enable restarts from WAIT_START.
